alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU instance (32-bit, 3-bit op, F/ZF/OF) among NREQ
//  requesters, e.g. the execute stage and the address/branch unit.
//  Round-robin arbitration, operand capture, one-cycle ALU evaluation and a
//  registered result with valid/ready backpressure.
//  Sits between the requesters and the ALU; the ALU stays purely combinational.
// PARAMETERS
//  NREQ   2   number of requesters, 2..4
//  WIDTH  32  operand/result width; must match the ALU
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           async, active-high reset
//  req        in   NREQ        per-requester request level; held until granted
//  req_a      in   NREQ*WIDTH  operand A; slice i belongs to requester i
//  req_b      in   NREQ*WIDTH  operand B; slice i
//  req_op     in   NREQ*3      ALU op; slice i
//  gnt        out  NREQ        one-hot, 1-cycle pulse: request i accepted this cycle
//  alu_a      out  WIDTH       registered operand A to the ALU
//  alu_b      out  WIDTH       registered operand B to the ALU
//  alu_op     out  3           registered op to the ALU
//  alu_f      in   WIDTH       ALU result
//  alu_zf     in   1           ALU zero flag
//  alu_of     in   1           ALU overflow/carry flag
//  rsp_valid  out  1           result valid
//  rsp_id     out  2           index of the requester that owns the result
//  rsp_f      out  WIDTH       captured result
//  rsp_zf     out  1           captured ZF
//  rsp_of     out  1           captured OF
//  rsp_ready  in   1           consumer accepts the result while rsp_valid=1
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr_ptr=0 (requester 0 has top priority).
//  FSM states:
//   IDLE -> EXEC when any req. In the same cycle: gnt[w]=1; A/B/op/id of the
//           winner w are registered into alu_*/cur_id.
//   EXEC -> RESP unconditionally. In this state the ALU output settles; at the
//           clock edge rsp_f/zf/of <= alu_f/zf/of, rsp_id <= cur_id and
//           rsp_valid <= 1.
//   RESP -> IDLE when rsp_ready=1; rsp_valid drops on that edge.
//           Hold while rsp_ready=0; rsp_* stay stable.
//  Latency: gnt in cycle N, rsp_valid in cycle N+2.
//   Best throughput is one op per 3 cycles; no gnt is issued in EXEC or RESP.
//  Arbitration: winner w is the first asserted req scanning from rr_ptr upward,
//   modulo NREQ. After a grant, rr_ptr <= (w+1) mod NREQ.
//   Bits of req at index >= NREQ are ignored.
//  A requester may drop req only after its gnt; the operands captured at gnt
//   are the ones used. Changing req_* after gnt has no effect.
//  alu_a/b/op hold their last values outside EXEC (no toggling when idle).
//  ALU ops (the ALU defines these; the bench model must match):
//   000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD (OF = carry out),
//   101 SUB (OF = borrow), 110 unsigned A<B -> 1/0, 111 A<<B.
//   ZF = (F==0) for all ops.
//  rst mid-operation: the in-flight op is discarded. rsp_valid=0 and gnt=0
//   immediately (async), FSM=IDLE, rr_ptr=0. The requester must re-request.
//  Simultaneous rsp_ready and a new req in RESP: the new req is granted only in
//   the following IDLE cycle.
// TESTING
//  1. req[0], A=5, B=3, op=100; rsp_ready=1 -> gnt[0] at N; at N+2 rsp_valid=1,
//     F=8, ZF=0, OF=0, id=0.
//  2. A=32'hFFFFFFFF, B=1, op=100 -> F=0, ZF=1, OF=1. Then A=0, B=1, op=101 ->
//     F=32'hFFFFFFFF, OF=1.
//  3. req=2'b11 held continuously, rsp_ready=1 -> grant order 0,1,0,1;
//     each rsp_id matches its grant.
//  4. rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, no gnt issued;
//     ready=1 -> IDLE next cycle, then next gnt.
//  5. Assert rst in EXEC -> rsp_valid stays 0, outputs 0. After release, a
//     pending req[1] is granted with rr_ptr=0 priority.
//  6. op=110 with A=1, B=32'h80000000 -> F=1 (unsigned compare). op=111 with
//     A=1, B=4 -> F=16.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among NREQ requesters: round-robin grant,
// operand capture, one-cycle evaluation and a response held under backpressure.
module alu_share_arbiter #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_op,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [2:0]            alu_op,
   input  logic [WIDTH-1:0]      alu_f,
   input  logic                  alu_zf,
   input  logic                  alu_of,
   output logic                  rsp_valid,
   output logic [1:0]            rsp_id,
   output logic [WIDTH-1:0]      rsp_f,
   output logic                  rsp_zf,
   output logic                  rsp_of,
   input  logic                  rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [1:0]       rr_ptr_r;
   logic [1:0]       cur_id_r;
   logic [3:0]       req_pad_s;
   logic [1:0]       win_s;
   logic             win_vld_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [2:0]       sel_op_s;

   function automatic logic [1:0] wrap_idx(input int base, input int offs);
      int sum;
      sum = (base + offs) % NREQ;
      return 2'(sum);
   endfunction

   // Padding to four bits lets a 2-bit index address any requester count
   assign req_pad_s = 4'(req);

   // Round-robin scan: first asserted request at or above rr_ptr_r, wrapping
   always_comb begin
      win_vld_s = 1'b0;
      win_s     = rr_ptr_r;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_vld_s && req_pad_s[wrap_idx(int'(rr_ptr_r), k)]) begin
            win_vld_s = 1'b1;
            win_s     = wrap_idx(int'(rr_ptr_r), k);
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Operand mux for the current winner
   always_comb begin
      sel_a_s  = '0;
      sel_b_s  = '0;
      sel_op_s = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         sel_a_s  = (win_s == 2'(i)) ? req_a[i*WIDTH +: WIDTH] : sel_a_s;
         sel_b_s  = (win_s == 2'(i)) ? req_b[i*WIDTH +: WIDTH] : sel_b_s;
         sel_op_s = (win_s == 2'(i)) ? req_op[i*3 +: 3]       : sel_op_s;
      end
   end

   // Grant is visible in the same IDLE cycle the winner is chosen; reset kills it at once
   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = !rst && (state_r == IDLE) && win_vld_s && (win_s == 2'(i));
      end
   end

   // Control FSM with operand capture and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         rr_ptr_r  <= 2'd0;
         cur_id_r  <= 2'd0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 2'd0;
         rsp_f     <= '0;
         rsp_zf    <= 1'b0;
         rsp_of    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (win_vld_s) begin
                  alu_a    <= sel_a_s;
                  alu_b    <= sel_b_s;
                  alu_op   <= sel_op_s;
                  cur_id_r <= win_s;
                  rr_ptr_r <= wrap_idx(int'(win_s), 1);
                  state_r  <= EXEC;
               end
            end
            EXEC: begin
               rsp_f     <= alu_f;
               rsp_zf    <= alu_zf;
               rsp_of    <= alu_of;
               rsp_id    <= cur_id_r;
               rsp_valid <= 1'b1;
               state_r   <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: transaction-level model of grants and
// responses, plus directed cases with hand-computed ALU results.
module tb_alu_share_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ*3-1:0] req_op;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic [2:0]        alu_op;
   logic [W-1:0]      alu_f;
   logic              alu_zf;
   logic              alu_of;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [W-1:0]      rsp_f;
   logic              rsp_zf;
   logic              rsp_of;
   logic              rsp_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_zf(rsp_zf),
      .rsp_of(rsp_of), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   // Returns {of, zf, f}
   function automatic logic [W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
      logic [W:0]   wide;
      logic [W-1:0] f;
      logic         of;
      of   = 1'b0;
      wide = '0;
      case (op)
         3'd0: f = a & b;
         3'd1: f = a | b;
         3'd2: f = a ^ b;
         3'd3: f = ~(a | b);
         3'd4: begin wide = {1'b0, a} + {1'b0, b}; f = wide[W-1:0]; of = wide[W]; end
         3'd5: begin f = a - b; of = (a < b); end
         3'd6: f = (a < b) ? W'(1) : W'(0);
         3'd7: f = a << b;
         default: f = '0;
      endcase
      return {of, (f == '0), f};
   endfunction

   // External ALU
   always_comb {alu_of, alu_zf, alu_f} = alu_ref(alu_a, alu_b, alu_op);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic rand_ops(input int i);
      int sel;
      sel = $urandom_range(0, 3);
      req_a[i*W +: W] = (sel == 0) ? W'($urandom) : (sel == 1) ? W'($urandom_range(0, 40)) :
                        (sel == 2) ? {W{1'b1}} : '0;
      req_b[i*W +: W] = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40));
      req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
   } txn_t;

   txn_t pend_q[$];
   int   free_at = 0;
   int   due     = 0;
   int   m_rr    = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      int              w;
      logic [NREQ-1:0] exp_g;
      logic            exp_v;
      logic [W+1:0]    r;
      txn_t            e;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_rsp", {rsp_id, rsp_zf, rsp_of, rsp_f}, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", {alu_op, alu_b}, 0);
            pend_q.delete();
            m_rr    = 0;
            free_at = 0;
         end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            end
            exp_g = '0;
            if (cyc >= free_at && w >= 0) exp_g[w] = 1'b1;
            chk("gnt", gnt, exp_g);
            if (exp_g != '0) begin
               e.id = w;
               e.a  = req_a[w*W +: W];
               e.b  = req_b[w*W +: W];
               e.op = req_op[w*3 +: 3];
               pend_q.push_back(e);
               due     = cyc + 2;
               free_at = 1 << 30;
               m_rr    = (w + 1) % NREQ;
            end else if (pend_q.size() > 0 && cyc == due - 1) begin
               chk("alu_a", alu_a, pend_q[0].a);
               chk("alu_b", alu_b, pend_q[0].b);
               chk("alu_op", alu_op, pend_q[0].op);
            end
            exp_v = (pend_q.size() > 0) && (cyc >= due);
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
               r = alu_ref(pend_q[0].a, pend_q[0].b, pend_q[0].op);
               chk("rsp_f", rsp_f, r[W-1:0]);
               chk("rsp_zf", rsp_zf, r[W]);
               chk("rsp_of", rsp_of, r[W+1]);
               chk("rsp_id", rsp_id, 2'(pend_q[0].id));
               if (rsp_ready) begin
                  void'(pend_q.pop_front());
                  free_at = cyc + 1;
               end
            end
         end
      end
   end

   // One directed op with literal expectations; latency gnt N -> valid N+2
   task automatic run_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] ef, input logic ezf,
                          input logic eof, input string tag);
      int n;
      @(posedge clk); #1;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_op[id*3 +: 3] = op;
      req[id]   = 1'b1;
      rsp_ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt[id] !== 1'b1 && n < 10);
      chk({tag, "_gnt"}, gnt, 64'(1 << id));
      @(posedge clk); #1;
      req[id] = 1'b0;
      req_a[id*W +: W] = ~a;
      @(negedge clk);
      chk({tag, "_exec_valid"}, rsp_valid, 0);
      @(negedge clk);
      chk({tag, "_valid"}, rsp_valid, 1);
      chk({tag, "_f"}, rsp_f, ef);
      chk({tag, "_zf"}, rsp_zf, ezf);
      chk({tag, "_of"}, rsp_of, eof);
      chk({tag, "_id"}, rsp_id, 2'(id));
   endtask

   initial begin
      int              n;
      logic [NREQ-1:0] g;
      rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_one(0, 32'd5, 32'd3, 3'b100, 32'd8, 1'b0, 1'b0, "add");
      run_one(0, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'd0, 1'b1, 1'b1, "add_carry");
      run_one(0, 32'd0, 32'd1, 3'b101, 32'hFFFF_FFFF, 1'b0, 1'b1, "sub_borrow");
      run_one(0, 32'd1, 32'h8000_0000, 3'b110, 32'd1, 1'b0, 1'b0, "sltu");
      run_one(1, 32'd1, 32'd4, 3'b111, 32'd16, 1'b0, 1'b0, "shl");

      // Both requesters held: strict alternation starting at requester 0
      @(posedge clk); #1;
      rand_ops(0); rand_ops(1); req = 2'b11; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (gnt == '0 && n < 10);
         chk("rr_order", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         @(posedge clk); #1;
         rand_ops(k % 2);
         n = 0;
         do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 10);
         chk("rr_id", rsp_id, 2'(k % 2));
      end
      @(posedge clk); #1 req = '0;

      // Backpressure: response held five cycles, no grant meanwhile
      @(posedge clk); #1;
      rand_ops(0); req = 2'b01; rsp_ready = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt[0] !== 1'b1 && n < 10);
      chk("hold_gnt0", gnt, 2'b01);
      @(posedge clk); #1;
      rand_ops(1); req = 2'b10;
      n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 10);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_nognt", gnt, 0);
         chk("hold_id", rsp_id, 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", rsp_valid, 1);
      chk("hold_release_nognt", gnt, 0);
      @(negedge clk);
      chk("hold_idle_valid", rsp_valid, 0);
      chk("hold_next_gnt", gnt, 2'b10);
      @(posedge clk); #1 req = '0;
      repeat (4) @(posedge clk);

      // Reset during EXEC discards the op and restores requester-0 priority
      #1;
      rand_ops(0); req = 2'b01; rsp_ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt[0] !== 1'b1 && n < 10);
      chk("rst_pre_gnt", gnt, 2'b01);
      @(posedge clk); #1;
      rst = 1'b1; rand_ops(1); req = 2'b11;
      @(negedge clk);
      chk("rst_exec_valid", rsp_valid, 0);
      chk("rst_exec_gnt", gnt, 0);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rr_gnt", gnt, 2'b01);
      @(posedge clk); #1 req[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt[1] !== 1'b1 && n < 10);
      chk("rst_gnt1", gnt, 2'b10);
      @(posedge clk); #1 req = '0;
      repeat (4) @(posedge clk);

      // Random traffic with random backpressure and one mid-run reset
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         g = gnt;
         @(posedge clk); #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (c == 200) rst = 1'b1;
         if (c == 202) rst = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
               req[i] = ($urandom_range(0, 1) != 0);
               rand_ops(i);
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               rand_ops(i);
            end
         end
      end
      @(posedge clk); #1;
      req = '0; rsp_ready = 1'b1;
      repeat (8) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
